// File: rtl/ddr_avmm_bridge.sv
// Bridges the matrix unit's shared DDR request port to an Avalon-MM host.
// Level-held requests with pulsed completions become one Avalon transaction
// at a time, with a read timeout and sticky error flags.
module ddr_avmm_bridge #(
    parameter int DataWidth     = 256,
    parameter int AddrWidth     = 26,
    parameter int AvmAddrWidth  = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AddrWidth-1:0]      ddr_address_i,
    input  logic                      ddr_w_en_i,
    input  logic [DataWidth-1:0]      ddr_w_data_i,
    output logic                      ddr_w_done_o,
    input  logic                      ddr_r_en_i,
    output logic [DataWidth-1:0]      ddr_r_data_o,
    output logic                      ddr_r_valid_o,
    output logic [AvmAddrWidth-1:0]   avm_address_o,
    output logic                      avm_read_o,
    output logic                      avm_write_o,
    output logic [DataWidth-1:0]      avm_writedata_o,
    output logic [DataWidth/8-1:0]    avm_byteenable_o,
    input  logic                      avm_waitrequest_i,
    input  logic [DataWidth-1:0]      avm_readdata_i,
    input  logic                      avm_readdatavalid_i,
    input  logic                      err_clear_i,
    output logic                      timeout_err_o,
    output logic                      stray_err_o
);

    localparam int ByteShift = $clog2(DataWidth / 8);
    localparam int CntWidth  = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CntWidth-1:0]       r_cnt;
    logic [AvmAddrWidth-1:0]   r_avm_address;
    logic [DataWidth-1:0]      r_avm_writedata;
    logic [DataWidth-1:0]      r_ddr_r_data;
    logic                      r_avm_read;
    logic                      r_avm_write;
    logic                      r_w_done;
    logic                      r_r_valid;
    logic                      r_timeout_err;
    logic                      r_stray_err;

    logic                      w_wr_accept;
    logic                      w_rd_accept;
    logic                      w_rd_data_hit;
    logic                      w_timeout_hit;
    logic                      w_stray_hit;
    logic                      w_avm_read_next;
    logic                      w_avm_write_next;
    logic                      w_w_done_next;
    logic                      w_r_valid_next;

    // Decode the events the FSM and datapath react to in the current state.
    always_comb begin
        w_wr_accept   = (r_state == S_IDLE) && ddr_w_en_i;
        w_rd_accept   = (r_state == S_IDLE) && !ddr_w_en_i && ddr_r_en_i;
        w_rd_data_hit = avm_readdatavalid_i &&
                        (((r_state == S_RD_REQ) && !avm_waitrequest_i) ||
                         (r_state == S_RD_WAIT));
        w_timeout_hit = (r_state == S_RD_WAIT) && !avm_readdatavalid_i &&
                        (r_cnt == CntLast);
        // Data with no read outstanding; RD_REQ before accept is not counted.
        w_stray_hit   = avm_readdatavalid_i &&
                        ((r_state == S_IDLE) || (r_state == S_WR_REQ) ||
                         (r_state == S_RESP));
    end

    // State register; reset aborts any transaction straight to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: write has priority over read, one transaction at a time.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_accept) begin
                    w_state_next = S_WR_REQ;
                end else if (w_rd_accept) begin
                    w_state_next = S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest_i) begin
                    w_state_next = S_RESP;
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest_i) begin
                    w_state_next = avm_readdatavalid_i ? S_RESP : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (w_rd_data_hit || w_timeout_hit) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, from the next state.
    always_comb begin
        w_avm_write_next = (w_state_next == S_WR_REQ);
        w_avm_read_next  = (w_state_next == S_RD_REQ);
        w_w_done_next    = (r_state == S_WR_REQ) && (w_state_next == S_RESP);
        w_r_valid_next   = w_rd_data_hit || w_timeout_hit;
    end

    // Output registers so no input reaches an output combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_avm_write <= 1'b0;
            r_avm_read  <= 1'b0;
            r_w_done    <= 1'b0;
            r_r_valid   <= 1'b0;
        end else begin
            r_avm_write <= w_avm_write_next;
            r_avm_read  <= w_avm_read_next;
            r_w_done    <= w_w_done_next;
            r_r_valid   <= w_r_valid_next;
        end
    end

    // Capture request fields, return read data (zero on timeout), run the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_ddr_r_data    <= '0;
            r_cnt           <= '0;
        end else begin
            if (w_wr_accept || w_rd_accept) begin
                r_avm_address <= AvmAddrWidth'(ddr_address_i) << ByteShift;
            end
            if (w_wr_accept) begin
                r_avm_writedata <= ddr_w_data_i;
            end
            if (w_rd_data_hit) begin
                r_ddr_r_data <= avm_readdata_i;
            end else if (w_timeout_hit) begin
                r_ddr_r_data <= '0;
            end
            if (r_state == S_RD_WAIT) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout_err <= 1'b0;
            r_stray_err   <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout_hit || (r_timeout_err && !err_clear_i);
            r_stray_err   <= w_stray_hit || (r_stray_err && !err_clear_i);
        end
    end

    assign ddr_w_done_o     = r_w_done;
    assign ddr_r_valid_o    = r_r_valid;
    assign ddr_r_data_o     = r_ddr_r_data;
    assign avm_address_o    = r_avm_address;
    assign avm_read_o       = r_avm_read;
    assign avm_write_o      = r_avm_write;
    assign avm_writedata_o  = r_avm_writedata;
    assign avm_byteenable_o = '1;
    assign timeout_err_o    = r_timeout_err;
    assign stray_err_o      = r_stray_err;

endmodule
